// File: rtl/dual_port_bram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dual_port_bram_pkg
// Description : Byte-lane helpers shared by the dual-port RAM and its output
//               registers.
//               No ports (package).
// Revision    : 1.0 - initial release
// ============================================================================
package dual_port_bram_pkg;

  localparam int unsigned BYTE_W = 8;

  // Number of byte-enable lanes in a word of width w.
  function automatic int unsigned lane_count(input int unsigned w);
    return w / BYTE_W;
  endfunction

endpackage : dual_port_bram_pkg
`default_nettype wire

// File: rtl/dual_port_bram_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : bram_out_reg
// Description : Read-data output register with synchronous reset and
//               hold-enable. The register loads d_i when en_i is high and
//               otherwise keeps its value.
//   clk   in  1  clock
//   rst   in  1  synchronous active-high reset (clears q_o)
//   en_i  in  1  load enable
//   d_i   in  W  data to capture
//   q_o   out W  registered data
// Revision    : 1.0 - initial release
// ============================================================================
module bram_out_reg #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en_i) begin
      data_d = d_i;
    end
  end

  // Reset wins over a load on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule : bram_out_reg
`default_nettype wire

// File: rtl/dual_port_bram.sv
`default_nettype none
// ============================================================================
// Module      : dual_port_bram
// Description : 2^ADDR_W x DATA_W synchronous RAM. Port A is a read-only
//               instruction port with a ready flag, port B a read/write data
//               port with per-byte write enables. All paths are read-first.
//   clk    in  1         shared clock
//   rst    in  1         synchronous active-high reset (outputs only)
//   ena    in  1         port A read request
//   addra  in  ADDR_W    port A word address
//   douta  out DATA_W    port A read data (1-cycle latency)
//   readya out 1         port A data valid (ena delayed one cycle)
//   enb    in  1         port B enable
//   web    in  DATA_W/8  port B byte write enables
//   renb   in  1         port B read request
//   addrb  in  ADDR_W    port B word address
//   dinb   in  DATA_W    port B write data
//   doutb  out DATA_W    port B read data (1-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module dual_port_bram
  import dual_port_bram_pkg::*;
#(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned DATA_W    = 64,
  parameter string       INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [ADDR_W-1:0]   addra,
  output logic [DATA_W-1:0]   douta,
  output logic                readya,
  input  logic                enb,
  input  logic [DATA_W/8-1:0] web,
  input  logic                renb,
  input  logic [ADDR_W-1:0]   addrb,
  input  logic [DATA_W-1:0]   dinb,
  output logic [DATA_W-1:0]   doutb
);

  localparam int unsigned LANES = lane_count(DATA_W);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Elaboration-time contents: zero.
  initial begin
    for (int k = 0; k < DEPTH; k++) begin
      mem[k] = '0;
    end
  end

  // Single write port. The array is never reset, so writes proceed even
  // while rst is asserted.
  always_ff @(posedge clk) begin
    if (enb) begin
      for (int i = 0; i < LANES; i++) begin
        if (web[i]) begin
          mem[addrb][i*BYTE_W +: BYTE_W] <= dinb[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Read data is taken from the array before this edge's write lands, which
  // makes both ports read-first against a same-address write.
  logic [DATA_W-1:0] rda_w;
  logic [DATA_W-1:0] rdb_w;
  logic              rdb_en_w;

  assign rda_w    = mem[addra];
  assign rdb_w    = mem[addrb];
  assign rdb_en_w = enb & renb;

  bram_out_reg #(.W(DATA_W)) u_out_a (
    .clk  (clk),
    .rst  (rst),
    .en_i (ena),
    .d_i  (rda_w),
    .q_o  (douta)
  );

  bram_out_reg #(.W(DATA_W)) u_out_b (
    .clk  (clk),
    .rst  (rst),
    .en_i (rdb_en_w),
    .d_i  (rdb_w),
    .q_o  (doutb)
  );

  // readya is ena delayed one cycle; no stall or back-pressure exists.
  logic readya_q;
  logic readya_d;

  assign readya_d = ena;

  always_ff @(posedge clk) begin
    if (rst) begin
      readya_q <= 1'b0;
    end else begin
      readya_q <= readya_d;
    end
  end

  assign readya = readya_q;

endmodule : dual_port_bram
`default_nettype wire

// File: tb/tb_dual_port_bram.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_port_bram
// Description : Scoreboard bench for dual_port_bram. Stimulus pushes the
//               expected read data; a monitor pops and compares whenever a
//               port presents data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_port_bram;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              ena;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] douta;
  logic              readya;
  logic              enb;
  logic [7:0]        web;
  logic              renb;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] dinb;
  logic [DATA_W-1:0] doutb;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] qa[$];
  logic [DATA_W-1:0] qb[$];
  logic              b_vld = 1'b0;

  always #5 clk = ~clk;

  dual_port_bram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_FILE("")) dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .addra  (addra),
    .douta  (douta),
    .readya (readya),
    .enb    (enb),
    .web    (web),
    .renb   (renb),
    .addrb  (addrb),
    .dinb   (dinb),
    .doutb  (doutb)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Port B has no valid output; a bench-side delayed copy of its read
  // request serves as the equivalent.
  always @(posedge clk) b_vld <= enb && renb && !rst;

  // Monitor: compare whenever a port presents data.
  always @(negedge clk) begin
    if (readya === 1'b1) begin
      if (qa.size() == 0) chk("a_unexpected_ready", 64'd1, 64'd0);
      else chk("douta", douta, qa.pop_front());
    end
    if (b_vld) begin
      if (qb.size() == 0) chk("b_unexpected_data", 64'd1, 64'd0);
      else chk("doutb", doutb, qb.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ena = 1'b0; enb = 1'b0; renb = 1'b0; web = 8'h00;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [7:0] be, input logic [63:0] d);
    idle();
    enb = 1'b1; web = be; addrb = a; dinb = d;
    cyc();
    idle();
  endtask

  // Read both ports at address a in the same cycle.
  task automatic rd2(input logic [ADDR_W-1:0] a, input logic [63:0] exp);
    idle();
    ena = 1'b1; addra = a; qa.push_back(exp);
    enb = 1'b1; renb = 1'b1; addrb = a; qb.push_back(exp);
    cyc();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; idle(); addra = '0; addrb = '0; dinb = '0;
    // Reset with ena held high: outputs stay cleared.
    ena = 1'b1;
    cyc();
    chk("rst_douta_1", douta, 64'd0);
    chk("rst_readya_1", {63'd0, readya}, 64'd0);
    chk("rst_doutb_1", doutb, 64'd0);
    cyc();
    chk("rst_douta_2", douta, 64'd0);
    chk("rst_readya_2", {63'd0, readya}, 64'd0);
    rst = 1'b0;
    qa.push_back(64'd0);
    cyc();
    chk("readya_after_release", {63'd0, readya}, 64'd1);
    idle();
    cyc();

    // Full word write then read on both ports.
    wr(14'd5, 8'hFF, 64'h0123456789ABCDEF);
    rd2(14'd5, 64'h0123456789ABCDEF);
    cyc();

    // Byte lanes.
    wr(14'd9, 8'hFF, 64'd0);
    wr(14'd9, 8'h81, 64'hAA000000000000BB);
    rd2(14'd9, 64'hAA000000000000BB);
    wr(14'd9, 8'h02, 64'h000000000000CC00);
    rd2(14'd9, 64'hAA0000000000CCBB);
    cyc();

    // Read-first collision on word 3.
    wr(14'd3, 8'hFF, 64'h1111);
    ena = 1'b1; addra = 14'd3; qa.push_back(64'h1111);
    enb = 1'b1; renb = 1'b1; web = 8'hFF; addrb = 14'd3; dinb = 64'h2222;
    qb.push_back(64'h1111);
    cyc();
    idle();
    chk("collision_readya", {63'd0, readya}, 64'd1);
    // Hold: requests dropped, data held, readya falls.
    cyc();
    chk("hold_readya", {63'd0, readya}, 64'd0);
    chk("hold_douta", douta, 64'h1111);
    chk("hold_doutb", doutb, 64'h1111);
    enb = 1'b1; renb = 1'b0; addrb = 14'd9;
    cyc();
    idle();
    chk("hold_douta_2", douta, 64'h1111);
    chk("hold_doutb_renb0", doutb, 64'h1111);
    rd2(14'd3, 64'h2222);
    cyc();

    // Write issued during reset still lands; outputs clear.
    rst = 1'b1;
    enb = 1'b1; web = 8'hFF; addrb = 14'd20; dinb = 64'hBEEF;
    cyc();
    idle();
    chk("rst2_douta", douta, 64'd0);
    chk("rst2_doutb", doutb, 64'd0);
    chk("rst2_readya", {63'd0, readya}, 64'd0);
    rst = 1'b0;
    rd2(14'd20, 64'hBEEF);
    cyc();

    // Streaming: preload words 0..7, then read one per cycle.
    for (int k = 0; k < 8; k++) begin
      wr(k[ADDR_W-1:0], 8'hFF, 64'hA5A5_0000_0000_0000 | 64'(k));
    end
    for (int k = 0; k < 8; k++) begin
      ena = 1'b1; addra = k[ADDR_W-1:0];
      qa.push_back(64'hA5A5_0000_0000_0000 | 64'(k));
      cyc();
      chk("stream_readya", {63'd0, readya}, 64'd1);
      chk("stream_douta", douta, 64'hA5A5_0000_0000_0000 | 64'(k));
    end
    idle();
    cyc();
    cyc();
    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_dual_port_bram
`default_nettype wire
